// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store requesters, round-robin on conflict.
// Write ack lands in the issue cycle, read ack LAT cycles after it; a waiting requester just holds its req.
module mem_port_arbiter #(
    parameter int NBITS  = 8,
    parameter int MWIDTH = 32,
    parameter int LAT    = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [NBITS-1:0]  if_addr_i,
    output logic              if_ack_o,
    output logic [MWIDTH-1:0] if_rdata_o,
    output logic              if_busy_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [NBITS-1:0]  d_addr_i,
    input  logic [MWIDTH-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [MWIDTH-1:0] d_rdata_o,
    output logic              d_busy_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [NBITS-1:0]  mem_addr_o,
    output logic [MWIDTH-1:0] mem_wdata_o,
    input  logic [MWIDTH-1:0] mem_rdata_i
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;     // 1 = data side won the last conflict
    logic              owner_q, owner_d;   // 1 = data side owns the port
    logic [NBITS-1:0]  addr_q, addr_d;
    logic              we_q, we_d;
    logic [MWIDTH-1:0] wdata_q, wdata_d;
    logic [MWIDTH-1:0] if_rdata_q, d_rdata_q;
    logic              grant_data;
    logic              done;

    assign grant_data = d_req_i & (~if_req_i | ~last_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_req_i | d_req_i) begin
                    state_d = S_ISSUE;
                    owner_d = grant_data;
                    addr_d  = grant_data ? d_addr_i : if_addr_i;
                    we_d    = grant_data & d_we_i;
                    if (grant_data) begin
                        wdata_d = d_wdata_i;
                    end
                    if (if_req_i & d_req_i) begin
                        last_d = grant_data;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Acks are masked during reset so an aborted access never completes.
    always_comb begin
        mem_en_o   = (state_q == S_ISSUE);
        mem_we_o   = (state_q == S_ISSUE) & we_q;
        done       = (((state_q == S_ISSUE) & we_q) | ((state_q == S_WAIT) & (cnt_q == '0))) & ~reset_i;
        if_ack_o   = done & ~owner_q;
        d_ack_o    = done & owner_q;
        if_rdata_o = if_ack_o ? mem_rdata_i : if_rdata_q;
        d_rdata_o  = (d_ack_o & ~we_q) ? mem_rdata_i : d_rdata_q;
        if_busy_o  = if_req_i & ~if_ack_o;
        d_busy_o   = d_req_i & ~d_ack_o;
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_o;
            d_rdata_q  <= d_rdata_o;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 instance for most steps, LAT=1 instance for the short-latency load.
// A small ROM with a LAT-deep read pipeline stands in for the memory.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0]  if_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        if_ack, if_busy, d_ack, d_busy, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] rd_p1 = '0, rd_p2 = '0;

    logic        d_req1 = 1'b0, if_req1 = 1'b0, d_we1 = 1'b0;
    logic [7:0]  if_addr1 = '0, d_addr1 = '0;
    logic [31:0] d_wdata1 = '0;
    logic        if_ack1, if_busy1, d_ack1, d_busy1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [7:0]  mem_addr1;
    logic [31:0] rd_q1 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic if_pend = 1'b0, d_pend = 1'b0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.NBITS(8), .MWIDTH(32), .LAT(2)) u_dut (
        .clock_i(clock), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata), .if_busy_o(if_busy),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack), .d_rdata_o(d_rdata), .d_busy_o(d_busy),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.NBITS(8), .MWIDTH(32), .LAT(1)) u_dut_lat1 (
        .clock_i(clock), .reset_i(reset),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_ack_o(if_ack1), .if_rdata_o(if_rdata1), .if_busy_o(if_busy1),
        .d_req_i(d_req1), .d_we_i(d_we1), .d_addr_i(d_addr1), .d_wdata_i(d_wdata1),
        .d_ack_o(d_ack1), .d_rdata_o(d_rdata1), .d_busy_o(d_busy1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
        .mem_rdata_i(mem_rdata1)
    );

    function automatic logic [31:0] rom(input logic [7:0] a);
        case (a)
            8'h00:   rom = 32'h0000_0013;
            8'h04:   rom = 32'h00A0_0093;
            8'h20:   rom = 32'hDEAD_BEEF;
            default: rom = 32'h0;
        endcase
    endfunction

    // Read data appears exactly LAT cycles after the address is presented.
    always @(posedge clock) begin
        rd_p1 <= rom(mem_addr);
        rd_p2 <= rd_p1;
        rd_q1 <= rom(mem_addr1);
    end
    assign mem_rdata  = rd_p2;
    assign mem_rdata1 = rd_q1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Protocol monitor: acks exclusive, and a pending req must not drop before its ack.
    always @(negedge clock) begin
        if (!reset) begin
            chk("ack_exclusive", 32'(if_ack & d_ack), 32'h0);
            chk("if_req_dropped", 32'(if_pend & ~if_req), 32'h0);
            chk("d_req_dropped", 32'(d_pend & ~d_req), 32'h0);
        end
        if_pend <= if_req & ~if_ack;
        d_pend  <= d_req & ~d_ack;
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        mid();
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_acks", 32'({if_ack, d_ack}), 32'h0);

        // 1: lone fetch of 0x04, LAT=2
        do_reset();
        if_req = 1'b1; if_addr = 8'h04;
        mid(); chk("t1_c0_mem_en", 32'(mem_en), 32'h0);
        adv(); mid();
        chk("t1_c1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_c1_mem_we", 32'(mem_we), 32'h0);
        chk("t1_c1_mem_addr", 32'(mem_addr), 32'h04);
        chk("t1_c1_if_ack", 32'(if_ack), 32'h0);
        chk("t1_c1_if_busy", 32'(if_busy), 32'h1);
        adv(); mid();
        chk("t1_c2_if_ack", 32'(if_ack), 32'h0);
        chk("t1_c2_mem_en", 32'(mem_en), 32'h0);
        adv(); mid();
        chk("t1_c3_if_ack", 32'(if_ack), 32'h1);
        chk("t1_c3_if_rdata", if_rdata, 32'h00A0_0093);
        chk("t1_c3_if_busy", 32'(if_busy), 32'h0);
        chk("t1_c3_d_ack", 32'(d_ack), 32'h0);
        adv(); if_req = 1'b0; mid();
        chk("t1_c4_if_ack", 32'(if_ack), 32'h0);
        chk("t1_c4_if_rdata_hold", if_rdata, 32'h00A0_0093);
        adv();

        // 2: store 0x5A to 0x10
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'h5A;
        mid();
        chk("t2_c0_d_ack", 32'(d_ack), 32'h0);
        chk("t2_c0_d_busy", 32'(d_busy), 32'h1);
        adv(); mid();
        chk("t2_c1_mem_en", 32'(mem_en), 32'h1);
        chk("t2_c1_mem_we", 32'(mem_we), 32'h1);
        chk("t2_c1_mem_addr", 32'(mem_addr), 32'h10);
        chk("t2_c1_mem_wdata", mem_wdata, 32'h5A);
        chk("t2_c1_d_ack", 32'(d_ack), 32'h1);
        chk("t2_c1_d_busy", 32'(d_busy), 32'h0);
        chk("t2_c1_if_ack", 32'(if_ack), 32'h0);
        adv(); d_req = 1'b0; d_we = 1'b0; mid();
        chk("t2_c2_mem_en", 32'(mem_en), 32'h0);
        chk("t2_c2_d_ack", 32'(d_ack), 32'h0);
        adv();

        // 3: both requesters held from reset release -> F, D, F, D
        do_reset();
        if_req = 1'b1; if_addr = 8'h04;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        for (int c = 0; c < 16; c++) begin
            if (c == 12) if_req = 1'b0;
            mid();
            chk($sformatf("t3_c%0d_if_ack", c), 32'(if_ack), 32'((c == 3) || (c == 11)));
            chk($sformatf("t3_c%0d_d_ack", c), 32'(d_ack), 32'((c == 7) || (c == 15)));
            if (c == 1 || c == 9) chk($sformatf("t3_c%0d_addr", c), 32'(mem_addr), 32'h04);
            if (c == 5 || c == 13) chk($sformatf("t3_c%0d_addr", c), 32'(mem_addr), 32'h20);
            if (c == 7) chk("t3_c7_d_rdata", d_rdata, 32'hDEAD_BEEF);
            if (c == 11) chk("t3_c11_if_rdata", if_rdata, 32'h00A0_0093);
            adv();
        end
        d_req = 1'b0;

        // 4: back-to-back fetches 0x00 then 0x04
        do_reset();
        if_req = 1'b1; if_addr = 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) if_addr = 8'h04;
            mid();
            chk($sformatf("t4_c%0d_if_ack", c), 32'(if_ack), 32'((c == 3) || (c == 7)));
            chk($sformatf("t4_c%0d_if_busy", c), 32'(if_busy), 32'((c != 3) && (c != 7)));
            if (c == 3) chk("t4_c3_if_rdata", if_rdata, 32'h0000_0013);
            if (c == 7) chk("t4_c7_if_rdata", if_rdata, 32'h00A0_0093);
            adv();
        end
        if_req = 1'b0;

        // 5: reset during WAIT of a load, then a fresh fetch
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        mid();
        adv(); mid();
        chk("t5_c1_mem_en", 32'(mem_en), 32'h1);
        adv(); reset = 1'b1; d_req = 1'b0; mid();
        chk("t5_c2_d_ack", 32'(d_ack), 32'h0);
        adv(); reset = 1'b0; if_req = 1'b1; if_addr = 8'h04; mid();
        chk("t5_c3_mem_en", 32'(mem_en), 32'h0);
        chk("t5_c3_d_ack", 32'(d_ack), 32'h0);
        chk("t5_c3_d_rdata", d_rdata, 32'h0);
        adv(); mid();
        chk("t5_c4_mem_en", 32'(mem_en), 32'h1);
        chk("t5_c4_mem_addr", 32'(mem_addr), 32'h04);
        chk("t5_c4_d_ack", 32'(d_ack), 32'h0);
        adv(); mid();
        chk("t5_c5_if_ack", 32'(if_ack), 32'h0);
        adv(); mid();
        chk("t5_c6_if_ack", 32'(if_ack), 32'h1);
        chk("t5_c6_if_rdata", if_rdata, 32'h00A0_0093);
        adv(); if_req = 1'b0;

        // 6: LAT=1 load from 0x20
        do_reset();
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 8'h20;
        mid();
        chk("t6_c0_mem_en", 32'(mem_en1), 32'h0);
        adv(); mid();
        chk("t6_c1_mem_en", 32'(mem_en1), 32'h1);
        chk("t6_c1_mem_addr", 32'(mem_addr1), 32'h20);
        chk("t6_c1_d_ack", 32'(d_ack1), 32'h0);
        adv(); mid();
        chk("t6_c2_d_ack", 32'(d_ack1), 32'h1);
        chk("t6_c2_d_rdata", d_rdata1, 32'hDEAD_BEEF);
        chk("t6_c2_if_ack", 32'(if_ack1), 32'h0);
        adv(); d_req1 = 1'b0; mid();
        chk("t6_c3_d_ack", 32'(d_ack1), 32'h0);
        chk("t6_c3_d_rdata_hold", d_rdata1, 32'hDEAD_BEEF);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
